// File: rtl/jpeg_stream_packer.sv
// -----------------------------------------------------------------------------
// jpeg_stream_packer
//
// Packs 32-bit entropy-coded words (MSB first) into a big-endian byte stream.
// A STUFF_BYTE is inserted after every 8'hFF data byte. The final word is cut
// to ceil(k/8) bytes, and its trailing bits are padded with 1s. The bytes are
// then regrouped into 32-bit output words. Only the last output word may be
// short (1..3 bytes).
//
// Optional feature: when the macro JPEG_PACK_EOI_EN is defined, the EOI marker
// (8'hFF, 8'hD9) is appended after the last data byte. It is never stuffed.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   in_valid/in_ready     encoder word handshake
//   in_data               32 coded bits, byte 0 = in_data[31:24]
//   in_last/in_last_bits  final word marker and its valid bit count (0 = 32)
//   out_valid/out_ready   packed word handshake
//   out_data/out_bytes    packed bytes (big-endian, unused bytes zero), count
//   out_last              final packed word of the stream
//   stream_bytes          bytes emitted in the current/last stream
//   done                  one-cycle pulse after the final word handshake
// -----------------------------------------------------------------------------
module jpeg_stream_packer #(
    parameter logic [7:0] STUFF_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [4:0]  in_last_bits,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_bytes,
    output logic        out_last,
    output logic [31:0] stream_bytes,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_ACCEPT    = 2'd0,
        ST_SERIALIZE = 2'd1,
`ifdef JPEG_PACK_EOI_EN
        ST_EOI       = 2'd2,
`endif
        ST_FLUSH     = 2'd3
    } state_t;

    // Writes byte b into slot idx (0 = most significant) of a left-aligned word.
    function automatic logic [31:0] place_byte(input logic [31:0] word,
                                               input logic [7:0]  b,
                                               input logic [2:0]  idx);
        case (idx)
            3'd0:    place_byte = word | {b, 24'h00_0000};
            3'd1:    place_byte = word | {8'h00, b, 16'h0000};
            3'd2:    place_byte = word | {16'h0000, b, 8'h00};
            3'd3:    place_byte = word | {24'h00_0000, b};
            default: place_byte = word;
        endcase
    endfunction

    state_t      state_r, state_nxt_s;
    logic [31:0] stg_data_r;
    logic [2:0]  stg_cnt_r;
    logic        stg_last_r;
    logic        stuff_pend_r;
    logic [31:0] asm_data_r;
    logic [2:0]  asm_cnt_r;
    logic        out_valid_r, out_last_r, done_r, first_r;
    logic [31:0] out_data_r, stream_bytes_r;
    logic [2:0]  out_bytes_r;
`ifdef JPEG_PACK_EOI_EN
    logic        eoi_idx_r;
`endif

    logic [5:0]  load_bits_s;
    logic [2:0]  load_cnt_s;
    logic [31:0] load_data_s;
    logic        accept_s, out_hs_s, out_ok_s, step_ok_s, step_fire_s;
    logic        step_req_s, step_consume_s, step_empties_s, step_final_s;
    logic [7:0]  step_byte_s;
    logic        flush_load_s, final_hs_s;
    logic [31:0] asm_next_s;

    assign in_ready     = (state_r == ST_ACCEPT) && !rst;
    assign accept_s     = in_valid && in_ready;
    assign out_hs_s     = out_valid_r && out_ready;
    assign out_ok_s     = !out_valid_r || out_ready;
    // A byte that completes the assembler must go straight into the output register.
    assign step_ok_s    = (asm_cnt_r != 3'd3) || out_ok_s;
    assign step_fire_s  = step_req_s && step_ok_s;
    assign asm_next_s   = place_byte(asm_data_r, step_byte_s, asm_cnt_r);

    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign out_bytes    = out_bytes_r;
    assign out_last     = out_last_r;
    assign stream_bytes = stream_bytes_r;
    assign done         = done_r;

    // Staging load: byte count and 1-padding of the final word's trailing bits.
    always_comb begin
        load_bits_s = (in_last_bits == 5'd0) ? 6'd32 : {1'b0, in_last_bits};
        if (in_last) begin
            load_cnt_s  = 3'((load_bits_s + 6'd7) >> 3);
            load_data_s = in_data | (32'hFFFF_FFFF >> load_bits_s);
        end else begin
            load_cnt_s  = 3'd4;
            load_data_s = in_data;
        end
    end

    // Next-state logic and selection of the byte moved into the assembler.
    always_comb begin
        state_nxt_s    = state_r;
        step_req_s     = 1'b0;
        step_byte_s    = 8'h00;
        step_consume_s = 1'b0;
        step_empties_s = 1'b0;
        step_final_s   = 1'b0;
        flush_load_s   = 1'b0;
        final_hs_s     = 1'b0;
        case (state_r)
            ST_ACCEPT: begin
                if (accept_s) begin
                    state_nxt_s = ST_SERIALIZE;
                end else begin
                    state_nxt_s = ST_ACCEPT;
                end
            end
            ST_SERIALIZE: begin
                step_req_s = 1'b1;
                if (stuff_pend_r) begin
                    step_byte_s    = STUFF_BYTE;
                    step_empties_s = (stg_cnt_r == 3'd0);
                end else begin
                    step_byte_s    = stg_data_r[31:24];
                    step_consume_s = 1'b1;
                    step_empties_s = (stg_cnt_r == 3'd1) && (stg_data_r[31:24] != 8'hFF);
                end
                if (step_ok_s && step_empties_s) begin
                    if (stg_last_r) begin
`ifdef JPEG_PACK_EOI_EN
                        state_nxt_s = ST_EOI;
`else
                        step_final_s = 1'b1;
                        state_nxt_s  = ST_FLUSH;
`endif
                    end else begin
                        state_nxt_s = ST_ACCEPT;
                    end
                end else begin
                    state_nxt_s = ST_SERIALIZE;
                end
            end
`ifdef JPEG_PACK_EOI_EN
            ST_EOI: begin
                step_req_s   = 1'b1;
                step_byte_s  = eoi_idx_r ? 8'hD9 : 8'hFF;
                step_final_s = eoi_idx_r;
                if (step_ok_s && eoi_idx_r) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_EOI;
                end
            end
`endif
            ST_FLUSH: begin
                // The last full word already carries out_last, so only residual bytes need a word.
                flush_load_s = (asm_cnt_r != 3'd0) && out_ok_s;
                final_hs_s   = out_hs_s && out_last_r;
                if (final_hs_s) begin
                    state_nxt_s = ST_ACCEPT;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            default: begin
                state_nxt_s = ST_ACCEPT;
            end
        endcase
    end

    // State, staging, assembler, output register and stream counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_ACCEPT;
            stg_data_r     <= 32'h0000_0000;
            stg_cnt_r      <= 3'd0;
            stg_last_r     <= 1'b0;
            stuff_pend_r   <= 1'b0;
            asm_data_r     <= 32'h0000_0000;
            asm_cnt_r      <= 3'd0;
            out_valid_r    <= 1'b0;
            out_data_r     <= 32'h0000_0000;
            out_bytes_r    <= 3'd0;
            out_last_r     <= 1'b0;
            stream_bytes_r <= 32'h0000_0000;
            done_r         <= 1'b0;
            first_r        <= 1'b1;
`ifdef JPEG_PACK_EOI_EN
            eoi_idx_r      <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            done_r  <= final_hs_s;

            if (accept_s) begin
                stg_data_r   <= load_data_s;
                stg_cnt_r    <= load_cnt_s;
                stg_last_r   <= in_last;
                stuff_pend_r <= 1'b0;
            end else if (step_fire_s && step_consume_s) begin
                stg_data_r   <= {stg_data_r[23:0], 8'h00};
                stg_cnt_r    <= stg_cnt_r - 3'd1;
                stuff_pend_r <= (step_byte_s == 8'hFF);
            end else if (step_fire_s) begin
                stuff_pend_r <= 1'b0;
            end

`ifdef JPEG_PACK_EOI_EN
            if (step_fire_s && (state_r == ST_EOI)) begin
                eoi_idx_r <= !eoi_idx_r;
            end
`endif

            if ((step_fire_s && (asm_cnt_r == 3'd3)) || flush_load_s) begin
                asm_data_r <= 32'h0000_0000;
                asm_cnt_r  <= 3'd0;
            end else if (step_fire_s) begin
                asm_data_r <= asm_next_s;
                asm_cnt_r  <= asm_cnt_r + 3'd1;
            end

            if (step_fire_s && (asm_cnt_r == 3'd3)) begin
                out_valid_r <= 1'b1;
                out_data_r  <= asm_next_s;
                out_bytes_r <= 3'd4;
                out_last_r  <= step_final_s;
            end else if (flush_load_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= asm_data_r;
                out_bytes_r <= asm_cnt_r;
                out_last_r  <= 1'b1;
            end else if (out_hs_s) begin
                out_valid_r <= 1'b0;
            end

            if (accept_s && first_r) begin
                stream_bytes_r <= 32'h0000_0000;
            end else if (out_hs_s) begin
                stream_bytes_r <= stream_bytes_r + {29'd0, out_bytes_r};
            end

            if (final_hs_s) begin
                first_r <= 1'b1;
            end else if (accept_s) begin
                first_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jpeg_stream_packer.sv
module tb_jpeg_stream_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [4:0]  in_last_bits;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic        out_last;
    logic [31:0] stream_bytes;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    // Input stream under test
    logic [31:0] w_data[$];
    logic        w_last[$];
    logic [4:0]  w_k[$];

    // Reference model output
    logic [31:0] exp_data[$];
    logic [2:0]  exp_bytes[$];
    logic        exp_last[$];
    int          exp_total;

    // Observed output
    logic [31:0] got_data[$];
    logic [2:0]  got_bytes[$];
    logic        got_last[$];
    int          acc_cyc, ov_cyc, stab_err, rdy_err;

    jpeg_stream_packer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_last_bits (in_last_bits),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_bytes    (out_bytes),
        .out_last     (out_last),
        .stream_bytes (stream_bytes),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Byte-level model: pad and cut words, stuff FF, optionally add EOI, regroup by 4.
    task automatic build_expected();
        logic [7:0]  bq[$];
        logic [31:0] d;
        logic [31:0] wd;
        logic [7:0]  b;
        int          n, nb, cnt;
        exp_data.delete(); exp_bytes.delete(); exp_last.delete();
        foreach (w_data[i]) begin
            n  = (w_last[i] && (w_k[i] != 5'd0)) ? int'(w_k[i]) : 32;
            nb = w_last[i] ? (n + 7) / 8 : 4;
            d  = w_data[i];
            if (w_last[i] && (n < 32)) d = d | (32'hFFFF_FFFF >> n);
            for (int j = 0; j < nb; j++) begin
                b = d[31 - 8*j -: 8];
                bq.push_back(b);
                if (b == 8'hFF) bq.push_back(8'h00);
            end
        end
`ifdef JPEG_PACK_EOI_EN
        bq.push_back(8'hFF);
        bq.push_back(8'hD9);
`endif
        exp_total = bq.size();
        for (int i = 0; i < bq.size(); i += 4) begin
            cnt = ((bq.size() - i) >= 4) ? 4 : (bq.size() - i);
            wd  = 32'h0;
            for (int j = 0; j < cnt; j++) wd[31 - 8*j -: 8] = bq[i + j];
            exp_data.push_back(wd);
            exp_bytes.push_back(3'(cnt));
            exp_last.push_back((i + cnt) == bq.size());
        end
    endtask

    // Drives the queued words and records output handshakes until done (bounded).
    // mode 0: out_ready=1, 1: toggling, 2: random valid/ready.
    task automatic drive_stream(input int mode, output int timed_out);
        int          idx = 0;
        int          cyc = 0;
        logic        seen_done = 1'b0;
        logic        prev_stall = 1'b0;
        logic        prev_acc = 1'b0;
        logic [31:0] pd = 32'h0;
        logic [2:0]  pb = 3'd0;
        logic        pl = 1'b0;
        got_data.delete(); got_bytes.delete(); got_last.delete();
        acc_cyc = -1; ov_cyc = -1; stab_err = 0; rdy_err = 0;
        while (!seen_done && (cyc < 3000)) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            in_valid = (idx < w_data.size()) && ((mode != 2) || ($urandom_range(0, 3) != 0));
            if (idx < w_data.size()) begin
                in_data = w_data[idx]; in_last = w_last[idx]; in_last_bits = w_k[idx];
            end else begin
                in_data = 32'h0; in_last = 1'b0; in_last_bits = 5'd0;
            end
            if (mode == 0)      out_ready = 1'b1;
            else if (mode == 1) out_ready = ((cyc % 2) == 0);
            else                out_ready = ($urandom_range(0, 2) != 0);
            if (seen_done) begin
                in_valid  = 1'b0;
                out_ready = 1'b0;
            end
            if (prev_stall && (!out_valid || (out_data !== pd) || (out_bytes !== pb) || (out_last !== pl)))
                stab_err++;
            if (prev_acc && in_ready) rdy_err++;
            if (out_valid && (ov_cyc < 0)) ov_cyc = cyc;
            prev_acc = in_valid && in_ready;
            if (prev_acc && (acc_cyc < 0)) acc_cyc = cyc;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_bytes.push_back(out_bytes);
                got_last.push_back(out_last);
            end
            prev_stall = out_valid && !out_ready;
            pd = out_data; pb = out_bytes; pl = out_last;
            if (prev_acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        timed_out = seen_done ? 0 : 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0;
        in_last_bits = 5'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b0)      begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_vec++; if (out_valid !== 1'b0)     begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 32'h0)     begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_vec++; if (out_bytes !== 3'd0)     begin n_err++; $display("FAIL reset_out_bytes: got %0d want 0", out_bytes); end
        n_vec++; if (out_last !== 1'b0)      begin n_err++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        n_vec++; if (stream_bytes !== 32'h0) begin n_err++; $display("FAIL reset_stream_bytes: got %0d want 0", stream_bytes); end
        n_vec++; if (done !== 1'b0)          begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1)      begin n_err++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_vectors();
        logic [31:0] vd[4] = '{32'h1234_5678, 32'hFF00_FF11, 32'hFE00_0000, 32'hA000_0000};
        logic [4:0]  vk[4] = '{5'd0, 5'd0, 5'd7, 5'd3};
        int          to;
        for (int v = 0; v < 4; v++) begin
            w_data = '{vd[v]}; w_last = '{1'b1}; w_k = '{vk[v]};
            build_expected();
            drive_stream(0, to);
            n_vec++; if (to != 0) begin n_err++; $display("FAIL vec%0d_timeout: no done pulse", v); end
            n_vec++; if (got_data.size() != exp_data.size()) begin
                n_err++; $display("FAIL vec%0d_word_count: got %0d want %0d", v, got_data.size(), exp_data.size());
            end else begin
                foreach (exp_data[i]) begin
                    if ((got_data[i] !== exp_data[i]) || (got_bytes[i] !== exp_bytes[i]) || (got_last[i] !== exp_last[i])) begin
                        n_err++; $display("FAIL vec%0d_word%0d: got %h/%0d/%b want %h/%0d/%b", v, i,
                                          got_data[i], got_bytes[i], got_last[i], exp_data[i], exp_bytes[i], exp_last[i]);
                    end
                end
            end
            n_vec++; if (stream_bytes !== 32'(exp_total)) begin
                n_err++; $display("FAIL vec%0d_stream_bytes: got %0d want %0d", v, stream_bytes, exp_total);
            end
            if (v == 0) begin
                n_vec++; if ((ov_cyc - acc_cyc) != 5) begin
                    n_err++; $display("FAIL vec0_latency: got %0d want 5", ov_cyc - acc_cyc);
                end
            end
            @(negedge clk);
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL vec%0d_done_pulse_width: got %b want 0", v, done); end
        end
    endtask

    task automatic test_back_to_back();
        int to;
        w_data = '{32'h0102_0304, 32'h0102_0304, 32'h0102_0304, 32'h0102_0304};
        w_last = '{1'b0, 1'b0, 1'b0, 1'b1};
        w_k    = '{5'd0, 5'd0, 5'd0, 5'd0};
        build_expected();
        drive_stream(1, to);
        n_vec++; if (to != 0) begin n_err++; $display("FAIL b2b_timeout: no done pulse"); end
        n_vec++; if (got_data.size() != exp_data.size()) begin
            n_err++; $display("FAIL b2b_word_count: got %0d want %0d", got_data.size(), exp_data.size());
        end else begin
            foreach (exp_data[i]) begin
                if ((got_data[i] !== exp_data[i]) || (got_bytes[i] !== exp_bytes[i]) || (got_last[i] !== exp_last[i])) begin
                    n_err++; $display("FAIL b2b_word%0d: got %h/%0d/%b want %h/%0d/%b", i,
                                      got_data[i], got_bytes[i], got_last[i], exp_data[i], exp_bytes[i], exp_last[i]);
                end
            end
        end
        n_vec++; if (stab_err != 0) begin n_err++; $display("FAIL b2b_stall_stability: got %0d changes want 0", stab_err); end
        n_vec++; if (rdy_err != 0)  begin n_err++; $display("FAIL b2b_in_ready_full: got %0d violations want 0", rdy_err); end
        n_vec++; if (stream_bytes !== 32'(exp_total)) begin
            n_err++; $display("FAIL b2b_stream_bytes: got %0d want %0d", stream_bytes, exp_total);
        end
    endtask

    task automatic test_random();
        int          to, nw;
        logic [31:0] d;
        for (int s = 0; s < 20; s++) begin
            w_data.delete(); w_last.delete(); w_k.delete();
            nw = $urandom_range(1, 6);
            for (int i = 0; i < nw; i++) begin
                for (int j = 0; j < 4; j++) d[8*j +: 8] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
                w_data.push_back(d);
                w_last.push_back(i == (nw - 1));
                w_k.push_back(5'($urandom_range(0, 31)));
            end
            build_expected();
            drive_stream(2, to);
            n_vec++; if (to != 0) begin n_err++; $display("FAIL rand%0d_timeout: no done pulse", s); end
            n_vec++; if (got_data.size() != exp_data.size()) begin
                n_err++; $display("FAIL rand%0d_word_count: got %0d want %0d", s, got_data.size(), exp_data.size());
            end else begin
                foreach (exp_data[i]) begin
                    if ((got_data[i] !== exp_data[i]) || (got_bytes[i] !== exp_bytes[i]) || (got_last[i] !== exp_last[i])) begin
                        n_err++; $display("FAIL rand%0d_word%0d: got %h/%0d/%b want %h/%0d/%b", s, i,
                                          got_data[i], got_bytes[i], got_last[i], exp_data[i], exp_bytes[i], exp_last[i]);
                    end
                end
            end
            n_vec++; if (stream_bytes !== 32'(exp_total)) begin
                n_err++; $display("FAIL rand%0d_stream_bytes: got %0d want %0d", s, stream_bytes, exp_total);
            end
            n_vec++; if (stab_err != 0) begin n_err++; $display("FAIL rand%0d_stall_stability: got %0d want 0", s, stab_err); end
        end
    endtask

    task automatic test_reset_mid_stream();
        int acc = 0;
        int cyc = 0;
        int to;
        out_ready = 1'b0;
        in_data = 32'h1122_3344; in_last = 1'b0; in_last_bits = 5'd0;
        while ((acc < 2) && (cyc < 100)) begin
            @(negedge clk);
            in_valid = 1'b1;
            if (in_ready) acc++;
            cyc++;
        end
        n_vec++; if (acc != 2) begin n_err++; $display("FAIL midrst_accept: got %0d words want 2", acc); end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0)     begin n_err++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (stream_bytes !== 32'h0) begin n_err++; $display("FAIL midrst_stream_bytes: got %0d want 0", stream_bytes); end
        rst = 1'b0;
        w_data = '{32'hAABB_CCDD}; w_last = '{1'b1}; w_k = '{5'd0};
        build_expected();
        drive_stream(0, to);
        n_vec++; if (to != 0) begin n_err++; $display("FAIL midrst_timeout: no done pulse"); end
        n_vec++; if ((got_data.size() != 1) || (got_data[0] !== exp_data[0]) || (got_bytes[0] !== exp_bytes[0]) || (got_last[0] !== exp_last[0])) begin
            n_err++; $display("FAIL midrst_new_stream: got %0d words first %h want 1 word %h", got_data.size(),
                              (got_data.size() > 0) ? got_data[0] : 32'h0, exp_data[0]);
        end
        n_vec++; if (stream_bytes !== 32'(exp_total)) begin
            n_err++; $display("FAIL midrst_stream_bytes_after: got %0d want %0d", stream_bytes, exp_total);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_random();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
